// File: rtl/latch_bank_wr_ctrl_if.sv
// Write-port bundle between two requesters and the latch-bank write controller.
// The controller takes the slave side; the requesters and latch rows take the master side.
interface latch_bank_wr_ctrl_if #(
    parameter int ROWS  = 8,
    parameter int AW    = 3,
    parameter int WIDTH = 32
);
    logic             REQ0;
    logic [AW-1:0]    ADDR0;
    logic [WIDTH-1:0] DATA0;
    logic             ACK0;
    logic             REQ1;
    logic [AW-1:0]    ADDR1;
    logic [WIDTH-1:0] DATA1;
    logic             ACK1;
    logic [WIDTH-1:0] WDATA;
    logic [ROWS-1:0]  EN;
    logic [ROWS-1:0]  nEN;
    logic             BUSY;

    modport master (
        output REQ0, ADDR0, DATA0, REQ1, ADDR1, DATA1,
        input  ACK0, ACK1, WDATA, EN, nEN, BUSY
    );

    modport slave (
        input  REQ0, ADDR0, DATA0, REQ1, ADDR1, DATA1,
        output ACK0, ACK1, WDATA, EN, nEN, BUSY
    );
endinterface

// File: rtl/latch_bank_wr_ctrl.sv
// Two-requester write sequencer for a bank of EN/nEN D-latch rows: SETUP, OPEN, CLOSE, then ACK.
// Define LATCH_BANK_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module latch_bank_wr_ctrl #(
    parameter int ROWS        = 8,
    parameter int AW          = 3,
    parameter int WIDTH       = 32,
    parameter int OPEN_CYCLES = 1
) (
    input logic                 CLK,
    input logic                 nRST,
    latch_bank_wr_ctrl_if.slave bus
);
    localparam int CW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, OPEN, CLOSE} state_t;

    state_t           state;
    logic [AW-1:0]    addrReg;
    logic [CW-1:0]    openCnt;
    logic             grantSel;
    logic [WIDTH-1:0] wdataReg;
    logic [ROWS-1:0]  enReg;
    logic [ROWS-1:0]  nEnReg;
    logic             ack0Reg;
    logic             ack1Reg;
    logic             busyReg;
    logic             win0;
    logic             win1;

    // Out-of-range addresses decode to an all-zero mask, so the write is silently dropped.
    function automatic logic [ROWS-1:0] rowMask(input logic [AW-1:0] a);
        logic [ROWS-1:0] m;
        m = '0;
        for (int i = 0; i < ROWS; i++)
            if (int'(a) == i) m[i] = 1'b1;
        return m;
    endfunction

`ifdef LATCH_BANK_RR_EN
    logic rrPtr;

    always_comb begin
        win1 = bus.REQ1 && (!bus.REQ0 || rrPtr);
        win0 = bus.REQ0 && !win1;
    end

    // Pointer flips to the other requester on every grant.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            rrPtr <= 1'b0;
        else if (state == IDLE && (win0 || win1))
            rrPtr <= win0;
    end
`else
    always_comb begin
        win0 = bus.REQ0;
        win1 = bus.REQ1 && !bus.REQ0;
    end
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            addrReg  <= '0;
            openCnt  <= '0;
            grantSel <= 1'b0;
            wdataReg <= '0;
            enReg    <= '0;
            nEnReg   <= '1;
            ack0Reg  <= 1'b0;
            ack1Reg  <= 1'b0;
            busyReg  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win0 || win1) begin
                        grantSel <= win1;
                        addrReg  <= win1 ? bus.ADDR1 : bus.ADDR0;
                        wdataReg <= win1 ? bus.DATA1 : bus.DATA0;
                        busyReg  <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    enReg   <= rowMask(addrReg);
                    nEnReg  <= ~rowMask(addrReg);
                    openCnt <= CW'(OPEN_CYCLES - 1);
                    state   <= OPEN;
                end
                OPEN: begin
                    if (openCnt == '0) begin
                        enReg   <= '0;
                        nEnReg  <= '1;
                        ack0Reg <= !grantSel;
                        ack1Reg <= grantSel;
                        state   <= CLOSE;
                    end else begin
                        openCnt <= openCnt - 1'b1;
                    end
                end
                CLOSE: begin
                    ack0Reg <= 1'b0;
                    ack1Reg <= 1'b0;
                    busyReg <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.WDATA = wdataReg;
    assign bus.EN    = enReg;
    assign bus.nEN   = nEnReg;
    assign bus.ACK0  = ack0Reg;
    assign bus.ACK1  = ack1Reg;
    assign bus.BUSY  = busyReg;
endmodule

// File: doc/latch_bank_wr_ctrl.md
Name: latch_bank_wr_ctrl

Overview:
Write sequencer and arbiter for a bank of complementary-enable D-latch rows, used for register-file and pipeline-register storage. Two requesters share one write port. The block captures the winning request and drives a stable WDATA bus. It then opens exactly one row's EN/nEN pair for a programmed number of cycles and closes it with a hold cycle before acknowledging. EN/nEN are always complementary and registered, so the latches never see glitches, overlap between rows or data changing while open.

Parameters:
ROWS, 8, number of latch rows (one EN/nEN pair each)
AW, 3, address width; ROWS <= 2**AW
WIDTH, 32, data width per row
OPEN_CYCLES, 1, cycles EN held high per write (>=1)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
REQ0  input  1  requester 0 write request
ADDR0  input  AW  requester 0 row address
DATA0  input  WIDTH  requester 0 write data
ACK0  output  1  requester 0 write complete, 1-cycle pulse
REQ1  input  1  requester 1 write request
ADDR1  input  AW  requester 1 row address
DATA1  input  WIDTH  requester 1 write data
ACK1  output  1  requester 1 write complete, 1-cycle pulse
WDATA  output  WIDTH  data bus to all latch D inputs
EN  output  ROWS  per-row latch enable, active high
nEN  output  ROWS  per-row complement of EN
BUSY  output  1  high whenever state != IDLE

Behaviour:
- Clock is CLK; reset is nRST, asynchronous and active-low; all flops clear immediately on nRST low.
- Reset values: EN=0, nEN=all 1s, WDATA=0, ACK0=ACK1=0, BUSY=0, state=IDLE, round-robin pointer=requester 0 preferred.
- FSM states: IDLE, SETUP, OPEN, CLOSE.
- IDLE: if any REQ is high at a rising edge, grant one requester; capture its ADDR and DATA into internal registers and load WDATA; go to SETUP. If neither REQ is high, stay in IDLE.
- SETUP, 1 cycle: WDATA stable, all EN=0. Next state is OPEN.
- OPEN, OPEN_CYCLES cycles: EN[addr]=1 and nEN[addr]=0; every other row is EN=0/nEN=1. A down-counter sets the duration. Next state is CLOSE.
- CLOSE, 1 cycle: all EN=0, WDATA still held (hold time). ACK of the granted requester =1 in this cycle only. Next state is IDLE.
- Latency: REQ sampled at edge N -> ACK high during cycle N+2+OPEN_CYCLES. Minimum spacing between grants is 3+OPEN_CYCLES cycles; a mandatory IDLE cycle follows every CLOSE.
- EN and nEN come from separate registers with identical next-state logic: nEN == ~EN on every cycle, including reset. At most one EN bit is ever high.
- WDATA changes only on the IDLE->SETUP edge.
- Requesters hold REQ/ADDR/DATA until ACK. After grant, inputs are ignored because they were captured. REQ dropped before grant is a withdrawal; no write occurs.
- ADDR >= ROWS: the transaction still goes through SETUP/OPEN/CLOSE and ACK is returned, but no EN bit is asserted (silent drop).
- Simultaneous REQ0 and REQ1 in IDLE: arbitration per the Optional Feature. The loser keeps waiting and is granted at the next IDLE if it is still requesting.
- Reset during OPEN: EN drops asynchronously and the row latches whatever was on D at that instant. Row content is undefined; other rows are untouched. No ACK is issued.
- ACK0 and ACK1 are never high in the same cycle.

Optional Feature:
LATCH_BANK_RR_EN
- Defined: round-robin arbitration. A 1-bit pointer selects the preferred requester on a tie. After each grant the pointer moves to the other requester; the update takes effect on the IDLE->SETUP edge.
- Undefined: fixed priority, REQ0 always wins a tie. The pointer flop is not built, and REQ1 can starve.

Test Plan:
- Reset: hold nRST=0 -> EN=8'h00, nEN=8'hFF, WDATA=0, BUSY=0, ACK0=ACK1=0. Check nEN==~EN every cycle for the whole test.
- Single write: REQ0=1, ADDR0=3, DATA0=32'hDEADBEEF, OPEN_CYCLES=1 -> WDATA=DEADBEEF a cycle before EN[3]=1; EN=8'h08 for exactly 1 cycle; ACK0 one cycle later; row-3 model latch holds DEADBEEF.
- Tie, REQ0 and REQ1 held continuously (ADDR0=1, ADDR1=2): with LATCH_BANK_RR_EN the ACK sequence is 0,1,0,1; without it the sequence is 0,0,0 and ACK1 never fires. Grants are spaced 4 cycles apart.
- Out-of-range address: ROWS=6, ADDR1=7 -> EN stays 0 throughout, ACK1 pulses at normal latency, all latch contents unchanged.
- Reset mid-write: OPEN_CYCLES=3, assert nRST=0 in the second OPEN cycle -> EN=0 asynchronously within the same cycle, no ACK, BUSY=0; a new write after release completes normally.
- Stability: during OPEN and CLOSE, toggle DATA0/ADDR0 every cycle -> WDATA and the EN pattern stay unchanged.
